sram_port_arbiter: RTL

Shares one synchronous SRAM-like memory port between the CPU instruction-fetch requester and the data load/store requester, for a unified-memory build of the top-level CPU wrapper. Arbitration runs per cycle. Data has priority, bounded by a starvation counter that guarantees fetch progress. Read data returns one cycle after grant and is routed to the requester that owned the access.

---
 rtl/sram_port_arbiter_pkg.sv | 23 ++
 rtl/sram_arb_pick.sv | 37 +++
 rtl/sram_port_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_port_arbiter_pkg: shared types for the unified SRAM arbiter      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam int STREAK_MAX_DEF = 4;
  localparam int STREAK_W = $clog2(STREAK_MAX_DEF + 1);

  // Counter must hold 0..STREAK_MAX; clamp to 1 bit so an illegal value still elaborates far enough to be flagged.
  function automatic int streak_width(input int streak_max);
    return (streak_max < 1) ? 1 : $clog2(streak_max + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_arb_pick: data-priority grant select with fetch-starvation limit |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sram_arb_pick #(
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = 3
) (
  input  logic                inst_req_i,
  input  logic                data_req_i,
  input  logic [STREAK_W-1:0] streak_q_i,
  output logic                inst_gnt_o,
  output logic                data_gnt_o,
  output logic [STREAK_W-1:0] streak_d_o
);

  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  logic streak_full;

  assign streak_full = (streak_q_i == STREAK_TOP);

  always_comb begin
    data_gnt_o = data_req_i & ~(inst_req_i & streak_full);
    inst_gnt_o = inst_req_i & ~data_gnt_o;
    streak_d_o = streak_q_i;
    if (inst_gnt_o || !inst_req_i) begin
      streak_d_o = '0;
    end else if (data_gnt_o) begin
      // Fetch is waiting behind a data grant: count it, saturating.
      streak_d_o = streak_full ? STREAK_TOP : streak_q_i + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_port_arbiter: shares one SRAM port between fetch and load/store  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = streak_width(STREAK_MAX);

  if (STREAK_MAX < 1) begin : g_streak_max_check
    $error("sram_port_arbiter: STREAK_MAX must be >= 1");
  end

  logic [CNT_W-1:0] streak_q, streak_d;
  owner_e           resp_owner_q, resp_owner_d;
  logic             pick_inst_gnt, pick_data_gnt;

  sram_arb_pick #(
    .STREAK_MAX(STREAK_MAX),
    .STREAK_W  (CNT_W)
  ) u_pick (
    .inst_req_i(inst_req),
    .data_req_i(data_req),
    .streak_q_i(streak_q),
    .inst_gnt_o(pick_inst_gnt),
    .data_gnt_o(pick_data_gnt),
    .streak_d_o(streak_d)
  );

  // Gating with resetn keeps the port quiet for the whole reset window, not just at edges.
  assign inst_gnt = pick_inst_gnt & resetn;
  assign data_gnt = pick_data_gnt & resetn;

  always_comb begin
    mem_en    = inst_gnt | data_gnt;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (data_gnt) begin
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (inst_gnt) begin
      mem_addr  = inst_addr;
    end
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (data_gnt && (data_wen == BE_W'(0))) begin
      resp_owner_d = OWN_DATA;
    end else if (inst_gnt) begin
      resp_owner_d = OWN_INST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_q     <= '0;
      resp_owner_q <= OWN_NONE;
    end else begin
      streak_q     <= streak_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign inst_rvalid = (resp_owner_q == OWN_INST);
  assign data_rvalid = (resp_owner_q == OWN_DATA);
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

endmodule
`default_nettype wire
